// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants, FSM state encoding and address/byte helpers
// for the direct-mapped write-through data cache.
//   get_index() - line index taken from a byte address
//   get_tag()   - tag field taken from a byte address
//   apply_be()  - merges the enabled bytes of a store word into a stored word
package dcache_pkg;

    localparam int DC_DATA_WIDTH = 32;
    localparam int DC_INDEX_BITS = 8;
    localparam int DC_TAG_BITS   = DC_DATA_WIDTH - DC_INDEX_BITS - 2;

    // Controller state encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_REFILL = 2'd1;
    localparam state_t ST_WRITE  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    function automatic logic [DC_INDEX_BITS-1:0] get_index(input logic [DC_DATA_WIDTH-1:0] addr);
        return addr[DC_INDEX_BITS+1:2];
    endfunction

    function automatic logic [DC_TAG_BITS-1:0] get_tag(input logic [DC_DATA_WIDTH-1:0] addr);
        return addr[DC_DATA_WIDTH-1:DC_INDEX_BITS+2];
    endfunction

    function automatic logic [DC_DATA_WIDTH-1:0] apply_be(input logic [DC_DATA_WIDTH-1:0] old_word,
                                                           input logic [DC_DATA_WIDTH-1:0] new_word,
                                                           input logic [3:0]               be);
        logic [DC_DATA_WIDTH-1:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_store.sv
// dcache_store: tag, data and valid storage for the direct-mapped cache.
// Ports:
//   clk, rst_n         - clock, async active-low reset (clears valid bits only)
//   rd_index           - combinational read port index
//   rd_tag/rd_data/rd_valid - contents of the addressed line
//   wr_en/wr_index/wr_tag/wr_data - single synchronous write port; a write
//                        always marks its line valid
//   clear_all          - invalidates every line at the next edge; a write in
//                        the same cycle still leaves its own line valid
module dcache_store
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = DC_DATA_WIDTH,
    parameter int INDEX_BITS = DC_INDEX_BITS,
    parameter int TAG_BITS   = DATA_WIDTH - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear_all
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [TAG_BITS-1:0]   tag_mem_r  [LINES];
    logic [DATA_WIDTH-1:0] data_mem_r [LINES];
    logic [LINES-1:0]      valid_r;

    assign rd_tag   = tag_mem_r[rd_index];
    assign rd_data  = data_mem_r[rd_index];
    assign rd_valid = valid_r[rd_index];

    // Valid bits: clear-all first, then the write sets its line so a fill wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else begin
            if (clear_all) begin
                valid_r <= '0;
            end
            if (wr_en) begin
                valid_r[wr_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem_r[wr_index]  <= wr_tag;
            data_mem_r[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-through, no-write-allocate data cache,
// one word per line.
// Ports:
//   cpu_re/cpu_we/cpu_addr/cpu_wdata/cpu_be - load/store request (store wins)
//   cpu_rdata/cpu_stall - load data (hit or completion) and pipeline hold
//   flush               - invalidate all lines
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be/mem_rdata/mem_ready -
//                         req/ready handshake to the backing memory
//   hit_count/miss_count - read hit and miss counters, wrapping
// Read hits answer in the same cycle; misses and all stores stall until the
// backing memory completes, followed by one DONE cycle that releases the CPU.
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = DC_DATA_WIDTH,
    parameter int INDEX_BITS = DC_INDEX_BITS,
    parameter int TAG_BITS   = DATA_WIDTH - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [3:0]            cpu_be,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    state_t state_r;
    state_t state_next_s;

    logic [INDEX_BITS-1:0] index_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic [TAG_BITS-1:0]   line_tag_s;
    logic [DATA_WIDTH-1:0] line_data_s;
    logic                  line_valid_s;
    logic                  hit_s;

    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] wr_data_s;

    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    assign index_s = get_index(cpu_addr);
    assign tag_s   = get_tag(cpu_addr);
    assign hit_s   = line_valid_s && (line_tag_s == tag_s);

    dcache_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (index_s),
        .rd_tag    (line_tag_s),
        .rd_data   (line_data_s),
        .rd_valid  (line_valid_s),
        .wr_en     (wr_en_s),
        .wr_index  (index_s),
        .wr_tag    (tag_s),
        .wr_data   (wr_data_s),
        .clear_all (flush)
    );

    // CPU- and memory-side outputs decoded from the current state.
    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        // The CPU holds its request during a stall, so these stay stable.
        mem_addr  = {cpu_addr[DATA_WIDTH-1:2], 2'b00};
        mem_wdata = cpu_wdata;
        mem_be    = cpu_be;
        case (state_r)
            ST_IDLE: begin
                if (cpu_we) begin
                    cpu_stall = 1'b1;
                end else if (cpu_re) begin
                    if (hit_s) begin
                        cpu_rdata = line_data_s;
                    end else begin
                        cpu_stall = 1'b1;
                    end
                end else begin
                    cpu_stall = 1'b0;
                end
            end
            ST_REFILL: begin
                mem_req   = 1'b1;
                cpu_stall = 1'b1;
            end
            ST_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                cpu_stall = 1'b1;
            end
            ST_DONE: begin
                cpu_rdata = line_data_s;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

    // Next state and the single array write issued when memory completes.
    always_comb begin
        state_next_s = state_r;
        wr_en_s      = 1'b0;
        wr_data_s    = line_data_s;
        case (state_r)
            ST_IDLE: begin
                if (cpu_we) begin
                    state_next_s = ST_WRITE;
                end else if (cpu_re && !hit_s) begin
                    state_next_s = ST_REFILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if (mem_ready) begin
                    // Fill proceeds even alongside flush: the new line stays valid.
                    wr_en_s      = 1'b1;
                    wr_data_s    = mem_rdata;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_REFILL;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    // Store hit merges into the line; a concurrent flush must not
                    // be undone by the write port re-setting the valid bit.
                    wr_en_s      = hit_s && !flush;
                    wr_data_s    = apply_be(line_data_s, cpu_wdata, cpu_be);
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Read hit/miss counters; only lookups in IDLE count, so a miss counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && cpu_re && !cpu_we) begin
            if (hit_s) begin
                hit_count_r <= hit_count_r + 32'd1;
            end else begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: a backing-memory responder with
// programmable latency, a reference of valid/tag state, and a scoreboard
// queue of expected load data.
module tb_dcache_direct;

    logic        clk;
    logic        rst_n;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dcache_direct dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_be     (cpu_be),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] bmem [logic [31:0]];
    bit          m_valid [256];
    logic [21:0] m_tag   [256];
    logic [31:0] exp_q [$];
    int          mem_lat = 1;
    int          req_cnt = 0;
    logic [31:0] hit_exp = 32'd0;
    logic [31:0] miss_exp = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (bmem.exists(w)) return bmem[w];
        return 32'h0000_0000;
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endfunction

    // Backing memory: mem_ready rises in the mem_lat-th cycle of a request.
    always @(negedge clk) begin
        if (mem_req) begin
            req_cnt = req_cnt + 1;
            if (req_cnt >= mem_lat) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    logic [31:0] w;
                    w = mem_word(mem_addr);
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                    bmem[mem_addr] = w;
                end else begin
                    mem_rdata = mem_word(mem_addr);
                end
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            req_cnt   = 0;
            mem_ready = 1'b0;
        end
    end

    task automatic check_idle();
        #1;
        check_value("idle_stall", {31'd0, cpu_stall}, 32'd0);
        check_value("idle_rdata", cpu_rdata, 32'd0);
        check_value("hit_count", hit_count, hit_exp);
        check_value("miss_count", miss_count, miss_exp);
    endtask

    task automatic do_load(input logic [31:0] addr, input int lat);
        int          idx;
        logic [21:0] tg;
        bit          exp_hit;
        bit          done;
        int          stalls;
        logic [31:0] exp_data;
        idx     = int'(addr[9:2]);
        tg      = addr[31:10];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        @(negedge clk);
        mem_lat  = lat;
        cpu_we   = 1'b0;
        cpu_re   = 1'b1;
        cpu_addr = addr;
        exp_q.push_back(mem_word(addr));
        done   = 1'b0;
        stalls = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (exp_hit) check_value("hit_no_req", {31'd0, mem_req}, 32'd0);
            if (cpu_stall) begin
                stalls++;
                @(negedge clk);
            end else begin
                exp_data = exp_q.pop_front();
                check_value("load_data", cpu_rdata, exp_data);
                done = 1'b1;
            end
        end
        check_value("load_done", {31'd0, done}, 32'd1);
        check_value("load_stalls", stalls, exp_hit ? 32'd0 : lat + 1);
        if (exp_hit) begin
            hit_exp++;
        end else begin
            miss_exp++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
        @(negedge clk);
        cpu_re = 1'b0;
        check_idle();
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input int lat);
        bit done;
        bit seen;
        int stalls;
        @(negedge clk);
        mem_lat   = lat;
        cpu_re    = 1'b0;
        cpu_we    = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_be    = be;
        done   = 1'b0;
        seen   = 1'b0;
        stalls = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (mem_req && !seen) begin
                seen = 1'b1;
                check_value("store_mem_we", {31'd0, mem_we}, 32'd1);
                check_value("store_mem_be", {28'd0, mem_be}, {28'd0, be});
                check_value("store_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                check_value("store_mem_wdata", mem_wdata, data);
            end
            if (cpu_stall) begin
                stalls++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        check_value("store_done", {31'd0, done}, 32'd1);
        check_value("store_req_seen", {31'd0, seen}, 32'd1);
        check_value("store_stalls", stalls, lat + 1);
        @(negedge clk);
        cpu_we = 1'b0;
        check_idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_be    = 4'h0;
        flush     = 1'b0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        clear_model();
        bmem[32'h0000_0100] = 32'hDEAD_BEEF;
        bmem[32'h0000_0500] = 32'h5555_0500;
        bmem[32'h0000_2000] = 32'h2000_2000;
        bmem[32'h0000_0300] = 32'h3333_0300;

        repeat (2) @(negedge clk);
        #1;
        check_value("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_value("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_value("rst_hit", hit_count, 32'd0);
        check_value("rst_miss", miss_count, 32'd0);
        check_value("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check_value("rst_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Miss with 3-cycle memory, then hits including an unaligned address.
        do_load(32'h0000_0100, 3);
        do_load(32'h0000_0100, 1);
        do_load(32'h0000_0103, 1);

        // Store hit merges the low byte; following load hits.
        do_store(32'h0000_0100, 32'h0000_00AA, 4'b0001, 1);
        do_load(32'h0000_0100, 1);
        check_value("merged_word", mem_word(32'h0000_0100), 32'hDEAD_BEAA);

        // Store miss does not allocate.
        do_store(32'h0000_2000, 32'h1234_5678, 4'b1100, 1);
        do_load(32'h0000_2000, 2);

        // Index conflict evicts 0x100.
        do_load(32'h0000_0500, 1);
        do_load(32'h0000_0100, 2);

        // Flush invalidates everything.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clear_model();
        do_load(32'h0000_0100, 1);

        // Reset in the middle of a refill.
        @(negedge clk);
        mem_lat  = 10;
        cpu_re   = 1'b1;
        cpu_addr = 32'h0000_0300;
        @(negedge clk);
        #1;
        check_value("refill_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        check_value("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        check_value("midrst_hit", hit_count, 32'd0);
        check_value("midrst_miss", miss_count, 32'd0);
        cpu_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        hit_exp  = 32'd0;
        miss_exp = 32'd0;
        do_load(32'h0000_0100, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
